// File: rtl/writeback_stage_pkg.sv
// ----------------------------------------------------------------------------
// writeback_stage_pkg
//   Shared definitions for the writeback stage: control-word bit indices,
//   access-size encodings and the halt/drain FSM state encoding.
// ----------------------------------------------------------------------------
package writeback_stage_pkg;

    // Control word layout (bit indices into control_in)
    localparam int CONTROL_BITS      = 8;
    localparam int CTL_REG_WE        = 0;
    localparam int CTL_MEM_READ      = 1;
    localparam int CTL_MEM_WE        = 2;
    localparam int CTL_LINK          = 3;
    localparam int CTL_ACCESS_SIZE_B1 = 4;
    localparam int CTL_ACCESS_SIZE_B2 = 5;
    localparam int CTL_LOAD_UNSIGNED = 6;
    localparam int CTL_HALT          = 7;

    // {ACCESS_SIZE_b1, ACCESS_SIZE_b2} encodings
    localparam logic [1:0] ACCESS_SIZE_WORD = 2'b00;
    localparam logic [1:0] ACCESS_SIZE_BYTE = 2'b01;
    localparam logic [1:0] ACCESS_SIZE_HALF = 2'b10;

    // Halt/drain FSM state encodings
    localparam logic [1:0] STATE_RUN_ENC    = 2'd0;
    localparam logic [1:0] STATE_DRAIN_ENC  = 2'd1;
    localparam logic [1:0] STATE_HALTED_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = STATE_RUN_ENC,
        ST_DRAIN  = STATE_DRAIN_ENC,
        ST_HALTED = STATE_HALTED_ENC
    } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// ----------------------------------------------------------------------------
// load_extract
//   Purely combinational load-data formatter. Picks a byte lane out of the
//   aligned memory word and sign/zero-extends it, or passes the full word.
//   Ports:
//     i_mem_word  32  aligned word from data memory (big-endian lanes)
//     i_offset     2  byte offset within the word (effective address LSBs)
//     i_size       2  {ACCESS_SIZE_b1, ACCESS_SIZE_b2}
//     i_unsigned   1  zero-extend instead of sign-extend
//     o_result    32  formatted load value
// ----------------------------------------------------------------------------
module load_extract
    import writeback_stage_pkg::*;
(
    input  logic [31:0] i_mem_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_result
);

    logic [7:0] w_byte;

    // Big-endian lanes: lane 0 is the most significant byte of the word.
    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0: w_byte = i_mem_word[31:24];
            2'd1: w_byte = i_mem_word[23:16];
            2'd2: w_byte = i_mem_word[15:8];
            2'd3: w_byte = i_mem_word[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        o_result = i_mem_word;
        if (i_size == ACCESS_SIZE_BYTE) begin
            if (i_unsigned) o_result = {24'h000000, w_byte};
            else            o_result = {{24{w_byte[7]}}, w_byte};
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// ----------------------------------------------------------------------------
// writeback_stage
//   Final pipeline stage. Selects ALU/link result or formatted load data,
//   drives the register-file write port (latency 1), exports a bypass copy
//   one cycle later (latency 2), counts retired instructions and runs the
//   halt/drain FSM that raises done at end of program.
//   Ports:
//     clk, reset                synchronous active-high reset
//     valid_in                  real instruction present (0 = bubble)
//     mem_data_in  32           word read from data memory
//     rd_data_in   32           ALU result / effective address / PC+8
//     rd_in         5           destination register
//     control_in   CONTROL_BITS control word
//     rf_we/rf_waddr/rf_wdata   register-file write port
//     byp_we/byp_rd/byp_data    previous-cycle write for WM forwarding
//     retired      RETIRE_W     retired non-bubble instruction count
//     done                      halted and drained
//
//   state  | meaning
//   RUN    | normal operation, instructions retire
//   DRAIN  | halt retired, inputs ignored, counting down DRAIN_CYCLES
//   HALTED | done=1, inputs ignored until reset
// ----------------------------------------------------------------------------
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int RETIRE_W     = 32,
    parameter int DRAIN_CYCLES = 2
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [31:0]             mem_data_in,
    input  logic [31:0]             rd_data_in,
    input  logic [4:0]              rd_in,
    input  logic [CONTROL_BITS-1:0] control_in,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic                    byp_we,
    output logic [4:0]              byp_rd,
    output logic [31:0]             byp_data,
    output logic [RETIRE_W-1:0]     retired,
    output logic                    done
);

    wb_state_t           r_state;
    logic [3:0]          r_drain_cnt;
    logic                r_rf_we;
    logic [4:0]          r_rf_waddr;
    logic [31:0]         r_rf_wdata;
    logic                r_byp_we;
    logic [4:0]          r_byp_rd;
    logic [31:0]         r_byp_data;
    logic [RETIRE_W-1:0] r_retired;
    logic                r_done;

    logic [31:0] w_load_data;
    logic [31:0] w_result;
    logic        w_accept;
    logic        w_unused_ctrl;

    // MEM_WE and LINK need no action here: stores simply lack REG_WE, and
    // the link value already arrives on rd_data_in.
    assign w_unused_ctrl = ^{control_in[CTL_MEM_WE], control_in[CTL_LINK]};

    load_extract u_load_extract (
        .i_mem_word (mem_data_in),
        .i_offset   (rd_data_in[1:0]),
        .i_size     ({control_in[CTL_ACCESS_SIZE_B1], control_in[CTL_ACCESS_SIZE_B2]}),
        .i_unsigned (control_in[CTL_LOAD_UNSIGNED]),
        .o_result   (w_load_data)
    );

    assign w_result = control_in[CTL_MEM_READ] ? w_load_data : rd_data_in;
    assign w_accept = valid_in && (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 4'd0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= 5'd0;
            r_rf_wdata  <= 32'd0;
            r_byp_we    <= 1'b0;
            r_byp_rd    <= 5'd0;
            r_byp_data  <= 32'd0;
            r_retired   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_byp_we   <= r_rf_we;
            r_byp_rd   <= r_rf_waddr;
            r_byp_data <= r_rf_wdata;
            r_rf_we    <= 1'b0;

            case (r_state)
                ST_RUN: begin
                    // Address/data follow the input even for r0 or bubbles;
                    // only the enable is qualified.
                    r_rf_waddr <= rd_in;
                    r_rf_wdata <= w_result;
                    r_rf_we    <= w_accept && control_in[CTL_REG_WE] && (rd_in != 5'd0);
                    if (w_accept) begin
                        r_retired <= r_retired + 1'b1;
                        if (control_in[CTL_HALT]) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= 4'(DRAIN_CYCLES);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt <= 4'd1) begin
                        r_state <= ST_HALTED;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 4'd1;
                    end
                end
                ST_HALTED: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign byp_we   = r_byp_we;
    assign byp_rd   = r_byp_rd;
    assign byp_data = r_byp_data;
    assign retired  = r_retired;
    assign done     = r_done;

endmodule

// File: tb/tb_writeback_stage.sv
// ----------------------------------------------------------------------------
// tb_writeback_stage
//   Directed stimulus; each vector pushes its expected outputs, tagged with
//   the cycle they must appear in, onto a scoreboard queue. A separate
//   monitor compares DUT outputs against due entries on every falling edge.
// ----------------------------------------------------------------------------
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam logic [7:0] C_REGWE = 8'h01;
    localparam logic [7:0] C_MRD   = 8'h02;
    localparam logic [7:0] C_MWE   = 8'h04;
    localparam logic [7:0] C_LINK  = 8'h08;
    localparam logic [7:0] C_BYTE  = 8'h20;
    localparam logic [7:0] C_UNS   = 8'h40;
    localparam logic [7:0] C_HALT  = 8'h80;

    localparam int K_WE = 0, K_WA = 1, K_WD = 2, K_BWE = 3, K_BRD = 4,
                   K_BD = 5, K_RET = 6, K_DONE = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] mem_data_in;
    logic [31:0] rd_data_in;
    logic [4:0]  rd_in;
    logic [7:0]  control_in;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        byp_we;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
    logic [31:0] retired;
    logic        done;

    writeback_stage #(.RETIRE_W(32), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .mem_data_in(mem_data_in), .rd_data_in(rd_data_in), .rd_in(rd_in),
        .control_in(control_in), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .byp_we(byp_we), .byp_rd(byp_rd),
        .byp_data(byp_data), .retired(retired), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int k);
        case (k)
            K_WE:   return {31'd0, rf_we};
            K_WA:   return {27'd0, rf_waddr};
            K_WD:   return rf_wdata;
            K_BWE:  return {31'd0, byp_we};
            K_BRD:  return {27'd0, byp_rd};
            K_BD:   return byp_data;
            K_RET:  return retired;
            default: return {31'd0, done};
        endcase
    endfunction

    function automatic string kname(int k);
        case (k)
            K_WE:   return "rf_we";
            K_WA:   return "rf_waddr";
            K_WD:   return "rf_wdata";
            K_BWE:  return "byp_we";
            K_BRD:  return "byp_rd";
            K_BD:   return "byp_data";
            K_RET:  return "retired";
            default: return "done";
        endcase
    endfunction

    // Monitor: compare every entry due in the current cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [31:0] act;
                act = actual(q[i].kind);
                n_cmp++;
                if (act !== q[i].val) begin
                    n_err++;
                    $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h",
                             kname(q[i].kind), cyc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input int off, input int kind, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc + off;
        e.kind = kind;
        e.val  = v;
        q.push_back(e);
    endtask

    // Drive one vector for one clock, after pushing its expected results.
    task automatic step(input logic rst, input logic v, input logic [7:0] ctl,
                        input logic [4:0] rd, input logic [31:0] rdd,
                        input logic [31:0] mem, input logic we, input bit chk,
                        input logic [4:0] ea, input logic [31:0] ed,
                        input logic [31:0] ret);
        expect_at(1, K_WE, {31'd0, we});
        expect_at(2, K_BWE, {31'd0, we});
        expect_at(1, K_RET, ret);
        if (chk) begin
            expect_at(1, K_WA, {27'd0, ea});
            expect_at(1, K_WD, ed);
            expect_at(2, K_BRD, {27'd0, ea});
            expect_at(2, K_BD, ed);
        end
        reset       = rst;
        valid_in    = v;
        control_in  = ctl;
        rd_in       = rd;
        rd_data_in  = rdd;
        mem_data_in = mem;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; control_in = 8'h00;
        rd_in = 5'd0; rd_data_in = 32'd0; mem_data_in = 32'd0;
        @(posedge clk);
        #1;

        // Reset state, with a valid write presented to show reset dominates.
        expect_at(1, K_DONE, 32'd0);
        step(1, 1, C_REGWE, 5'd3, 32'h77, 0, 0, 1, 5'd0, 32'd0, 32'd0);

        // ALU writeback
        step(0, 1, C_REGWE, 5'd5, 32'h0000_1234, 0, 1, 1, 5'd5, 32'h0000_1234, 32'd1);
        // Byte loads: signed offset 1, unsigned offset 1, signed offset 3, word
        step(0, 1, C_REGWE|C_MRD|C_BYTE, 5'd6, 32'h0000_1001, 32'h11F2_3384,
             1, 1, 5'd6, 32'hFFFF_FFF2, 32'd2);
        step(0, 1, C_REGWE|C_MRD|C_BYTE|C_UNS, 5'd6, 32'h0000_1001, 32'h11F2_3384,
             1, 1, 5'd6, 32'h0000_00F2, 32'd3);
        step(0, 1, C_REGWE|C_MRD|C_BYTE, 5'd7, 32'h0000_1003, 32'h11F2_3384,
             1, 1, 5'd7, 32'hFFFF_FF84, 32'd4);
        step(0, 1, C_REGWE|C_MRD, 5'd8, 32'h0000_1003, 32'h11F2_3384,
             1, 1, 5'd8, 32'h11F2_3384, 32'd5);
        // r0 write suppressed, address/data still follow
        step(0, 1, C_REGWE, 5'd0, 32'h0000_DEAD, 0, 0, 1, 5'd0, 32'h0000_DEAD, 32'd6);
        // Store
        step(0, 1, C_MWE, 5'd7, 32'h0000_2000, 0, 0, 0, 5'd0, 32'd0, 32'd7);
        // Bubble
        step(0, 0, C_REGWE, 5'd8, 32'h0000_3000, 0, 0, 0, 5'd0, 32'd0, 32'd7);
        // JAL
        step(0, 1, C_REGWE|C_LINK, 5'd31, 32'h0040_0010, 0, 1, 1, 5'd31, 32'h0040_0010, 32'd8);

        // Halt at T with its own register write; done must rise at T+3.
        expect_at(1, K_DONE, 32'd0);
        expect_at(2, K_DONE, 32'd0);
        expect_at(3, K_DONE, 32'd1);
        step(0, 1, C_HALT|C_REGWE, 5'd9, 32'h0000_0099, 0, 1, 1, 5'd9, 32'h0000_0099, 32'd9);
        step(0, 1, C_REGWE, 5'd10, 32'h0000_0055, 0, 0, 0, 5'd0, 32'd0, 32'd9);
        step(0, 1, C_REGWE, 5'd11, 32'h0000_0066, 0, 0, 0, 5'd0, 32'd0, 32'd9);
        expect_at(1, K_DONE, 32'd1);
        step(0, 1, C_REGWE, 5'd12, 32'h0000_0077, 0, 0, 0, 5'd0, 32'd0, 32'd9);
        expect_at(1, K_DONE, 32'd1);
        step(0, 0, 8'h00, 5'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0, 32'd9);

        // Reset from HALTED
        expect_at(1, K_DONE, 32'd0);
        step(1, 0, 8'h00, 5'd0, 32'd0, 0, 0, 1, 5'd0, 32'd0, 32'd0);

        // Halt without a write, then reset mid-drain at T+2.
        expect_at(1, K_DONE, 32'd0);
        expect_at(2, K_DONE, 32'd0);
        step(0, 1, C_HALT, 5'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0, 32'd1);
        step(0, 0, 8'h00, 5'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0, 32'd1);
        expect_at(1, K_DONE, 32'd0);
        step(1, 0, 8'h00, 5'd0, 32'd0, 0, 0, 1, 5'd0, 32'd0, 32'd0);
        expect_at(1, K_DONE, 32'd0);
        step(0, 1, C_REGWE, 5'd12, 32'h0000_ABCD, 0, 1, 1, 5'd12, 32'h0000_ABCD, 32'd1);
        expect_at(1, K_DONE, 32'd0);
        step(0, 0, 8'h00, 5'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0, 32'd1);
        step(0, 0, 8'h00, 5'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0, 32'd1);

        repeat (4) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0 pending", q.size());
            n_err += q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
